// File: rtl/pixel_compositor_pkg.sv
// Shared definitions for the video path: screen and sprite geometry, colour
// format, the transparent colour key, game state encodings used by the scan
// stage and game FSM, and the compositor's own state and pipeline tag types.
package pixel_compositor_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int SPR_W = 32;
    localparam int SPR_H = 32;
    localparam int CW    = 9;

    localparam logic [CW-1:0] KEY = 9'h1FF;

    typedef enum logic [2:0] {
        Start,
        Game,
        Game_Hit,
        Game_Miss,
        GameEnd
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH
    } comp_state_t;

    // Per-pixel information carried alongside the ROM reads.
    typedef struct packed {
        logic       vld;
        logic [7:0] x;
        logic [6:0] y;
        logic       hit;
    } pix_tag_t;

endpackage

// File: rtl/pixel_compositor_delay_pipe.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Ports:
//   clock, resetn : clock and async active-low clear
//   i_d           : data entering stage 0
//   o_q           : data leaving the last stage (DEPTH cycles later)
module pixel_compositor_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [DEPTH-1:0][W-1:0] r_pipe;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Composites one colour-keyed mole sprite over the background pixel stream
// and drives the VGA adapter plot interface for a 160x120 frame.
// Ports:
//   clock, resetn         : clock, async active-low reset
//   pix_valid/x/y         : background stream pixel (bg ROM already addressed)
//   scan_done             : pulse from scan stage after its last pixel
//   bg_colour             : background ROM data, ROM_LAT cycles after pix_valid
//   mole_x/y/show         : sprite position and enable, latched at frame start
//   spr_address/colour    : sprite ROM address out, data back ROM_LAT later
//   vga_x/y/colour/plot   : VGA adapter plot interface
//   frame_done            : pulse one cycle after the last plot of a frame
//   busy                  : frame in flight
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pix_valid,
    input  logic [7:0]    pix_x,
    input  logic [7:0]    pix_y,
    input  logic          scan_done,
    input  logic [CW-1:0] bg_colour,
    input  logic [7:0]    mole_x,
    input  logic [7:0]    mole_y,
    input  logic          mole_show,
    output logic [9:0]    spr_address,
    input  logic [CW-1:0] spr_colour,
    output logic [7:0]    vga_x,
    output logic [6:0]    vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic          frame_done,
    output logic          busy
);

    comp_state_t   r_state, w_next;
    logic [1:0]    r_cnt;
    logic          w_flush_end;
    logic          r_frame_done;

    logic [7:0]    r_sx, r_sy;
    logic          r_show;
    logic [7:0]    w_sx, w_sy;
    logic          w_show;
    logic          w_start;

    logic [8:0]    w_x9, w_y9, w_sx9, w_sy9;
    logic          w_onscr, w_hit;
    logic [4:0]    w_dx, w_dy;
    logic [9:0]    r_spr_addr;
    logic [CW-1:0] r_bg;
    pix_tag_t      w_tag_in, w_tag_out;

    // ---------------- frame FSM ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (pix_valid)   w_next = DRAW;
            DRAW:    if (scan_done)   w_next = FLUSH;
            FLUSH:   if (w_flush_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        w_start     = (r_state == IDLE) && pix_valid;
        // FLUSH spans ROM_LAT+1 cycles, i.e. until the last pixel has plotted.
        w_flush_end = (r_state == FLUSH) && (r_cnt == 2'(ROM_LAT));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= (r_state == FLUSH) ? r_cnt + 2'd1 : 2'd0;
            r_frame_done <= w_flush_end;
        end
    end

    assign frame_done = r_frame_done;

    // ---------------- sprite latch ----------------
    // The first pixel of a frame must already see the new sprite position,
    // so in IDLE the live inputs are used directly.
    assign w_sx   = (r_state == IDLE) ? mole_x    : r_sx;
    assign w_sy   = (r_state == IDLE) ? mole_y    : r_sy;
    assign w_show = (r_state == IDLE) ? mole_show : r_show;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sx   <= '0;
            r_sy   <= '0;
            r_show <= 1'b0;
        end else if (w_start) begin
            r_sx   <= mole_x;
            r_sy   <= mole_y;
            r_show <= mole_show;
        end
    end

    // ---------------- stage 0: hit test and sprite address ----------------
    // 9-bit compares so a sprite near the right/bottom edge clips rather than wraps.
    assign w_x9  = {1'b0, pix_x};
    assign w_y9  = {1'b0, pix_y};
    assign w_sx9 = {1'b0, w_sx};
    assign w_sy9 = {1'b0, w_sy};

    assign w_onscr = pix_valid && (pix_x < 8'(SCR_W)) && (pix_y < 8'(SCR_H));
    assign w_hit   = pix_valid && w_show
                  && (w_x9 >= w_sx9) && (w_x9 < w_sx9 + 9'(SPR_W))
                  && (w_y9 >= w_sy9) && (w_y9 < w_sy9 + 9'(SPR_H));

    // With a 32-pixel-wide sprite, dy*SPR_W+dx is just {dy,dx}.
    assign w_dx = pix_x[4:0] - w_sx[4:0];
    assign w_dy = pix_y[4:0] - w_sy[4:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)    r_spr_addr <= '0;
        else if (w_hit) r_spr_addr <= {w_dy, w_dx};
    end

    assign spr_address = r_spr_addr;

    // ---------------- alignment pipeline ----------------
    assign w_tag_in = '{vld: w_onscr, x: pix_x, y: pix_y[6:0], hit: w_hit};

    pixel_compositor_delay_pipe #(
        .DEPTH (ROM_LAT + 1),
        .W     ($bits(pix_tag_t))
    ) u_tag_pipe (
        .clock  (clock),
        .resetn (resetn),
        .i_d    (w_tag_in),
        .o_q    (w_tag_out)
    );

    // Background data arrives one cycle ahead of sprite data (the sprite
    // address is itself registered), so one register lines them up.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_bg <= '0;
        else         r_bg <= bg_colour;
    end

    // ---------------- output stage ----------------
    assign vga_plot   = w_tag_out.vld;
    assign vga_x      = w_tag_out.x;
    assign vga_y      = w_tag_out.y;
    assign vga_colour = (w_tag_out.hit && (spr_colour != KEY)) ? spr_colour : r_bg;

endmodule

// File: tb/tb_pixel_compositor.sv
module tb_pixel_compositor;
    import pixel_compositor_pkg::*;

    typedef struct {
        int x;
        int y;
        int col;
        int cyc;
    } rec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_x = '0, pix_y = '0;
    logic       scan_done = 1'b0;
    logic [7:0] mole_x = '0, mole_y = '0;
    logic       mole_show = 1'b0;

    logic [8:0] bg1 = '0, spr1 = '0;
    logic [9:0] sa1;
    logic [7:0] vx1;
    logic [6:0] vy1;
    logic [8:0] vc1;
    logic       vp1, fd1, bz1;

    logic [8:0] bg3p [3];
    logic [8:0] spr3p [3];
    logic [8:0] bg3, spr3;
    logic [9:0] sa3;
    logic [7:0] vx3;
    logic [6:0] vy3;
    logic [8:0] vc3;
    logic       vp3, fd3, bz3;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   e_sx = 0, e_sy = 0;
    bit   e_show = 0;
    int   spr_mode = 0;
    int   rst_cyc;
    int   late;

    rec_t exp_q[$];
    rec_t act1[$];
    rec_t act3[$];
    int   fdq1[$];
    int   fdq3[$];

    always #5 clock = ~clock;

    pixel_compositor #(.ROM_LAT(1)) dut1 (
        .clock(clock), .resetn(resetn), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .scan_done(scan_done), .bg_colour(bg1), .mole_x(mole_x), .mole_y(mole_y),
        .mole_show(mole_show), .spr_address(sa1), .spr_colour(spr1), .vga_x(vx1),
        .vga_y(vy1), .vga_colour(vc1), .vga_plot(vp1), .frame_done(fd1), .busy(bz1)
    );

    assign bg3  = bg3p[2];
    assign spr3 = spr3p[2];

    pixel_compositor #(.ROM_LAT(3)) dut3 (
        .clock(clock), .resetn(resetn), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .scan_done(scan_done), .bg_colour(bg3), .mole_x(mole_x), .mole_y(mole_y),
        .mole_show(mole_show), .spr_address(sa3), .spr_colour(spr3), .vga_x(vx3),
        .vga_y(vy3), .vga_colour(vc3), .vga_plot(vp3), .frame_done(fd3), .busy(bz3)
    );

    // Background ROM contents: colour = (y*160+x)[8:0].
    function automatic logic [8:0] bgfun(int x, int y);
        int a;
        a = (y * 160 + x) & 511;
        return 9'(a);
    endfunction

    // Sprite ROM contents; address 0 is always transparent.
    function automatic logic [8:0] sprfun(logic [9:0] a);
        if (a == 10'd0) return 9'h1FF;
        if (spr_mode == 0) return 9'h0E0;
        return {1'b0, a[7:0]} ^ 9'h055;
    endfunction

    function automatic int exp_col(int x, int y);
        int a;
        int s;
        if (e_show && x >= e_sx && x < e_sx + 32 && y >= e_sy && y < e_sy + 32) begin
            a = (y - e_sy) * 32 + (x - e_sx);
            s = int'(sprfun(10'(a)));
            if (s != 511) return s;
        end
        return int'(bgfun(x, y));
    endfunction

    function automatic int find_col(rec_t q[$], int x, int y);
        foreach (q[i]) if (q[i].x == x && q[i].y == y) return q[i].col;
        return -1;
    endfunction

    // Synchronous ROM models: data valid ROM_LAT cycles after the address.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        bg1      <= bgfun(int'(pix_x), int'(pix_y));
        spr1     <= sprfun(sa1);
        bg3p[0]  <= bgfun(int'(pix_x), int'(pix_y));
        bg3p[1]  <= bg3p[0];
        bg3p[2]  <= bg3p[1];
        spr3p[0] <= sprfun(sa3);
        spr3p[1] <= spr3p[0];
        spr3p[2] <= spr3p[1];
    end

    always @(negedge clock) begin
        if (vp1) act1.push_back('{x: int'(vx1), y: int'(vy1), col: int'(vc1), cyc: cyc});
        if (vp3) act3.push_back('{x: int'(vx3), y: int'(vy3), col: int'(vc3), cyc: cyc});
        if (fd1) fdq1.push_back(cyc);
        if (fd3) fdq3.push_back(cyc);
    end

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic drive_pix(input int x, input int y, input bit sd);
        @(negedge clock);
        pix_valid = 1'b1;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        scan_done = sd;
        if (x < 160 && y < 120) exp_q.push_back('{x: x, y: y, col: exp_col(x, y), cyc: cyc});
    endtask

    task automatic idle();
        @(negedge clock);
        pix_valid = 1'b0;
        scan_done = 1'b0;
    endtask

    // Raster-scan a rectangle; optional 1-cycle gap after every 4th pixel,
    // scan_done on the final pixel when 'last', early return after stop_at pixels.
    task automatic run_rect(input int x0, input int x1, input int y0, input int y1,
                            input bit gap, input bit last, input int stop_at);
        int n;
        n = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (n == stop_at) return;
                drive_pix(x, y, last && x == x1 && y == y1);
                n++;
                if (gap && (n % 4) == 0) idle();
            end
        end
        idle();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !(fdq1.size() > 0 && fdq3.size() > 0); i++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_dut(input string tag, input rec_t act[$], input int fdq[$], input int lat);
        int nbad;
        int nlat;
        int n;
        nbad = 0;
        nlat = 0;
        n = (act.size() < exp_q.size()) ? act.size() : exp_q.size();
        chk({tag, " plot count"}, act.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            if (act[i].x != exp_q[i].x || act[i].y != exp_q[i].y || act[i].col != exp_q[i].col)
                nbad++;
            if (act[i].cyc != exp_q[i].cyc + lat + 1) nlat++;
        end
        chk({tag, " pixel mismatches"}, nbad, 0);
        chk({tag, " latency errors"}, nlat, 0);
        chk({tag, " frame_done pulses"}, fdq.size(), 1);
        if (fdq.size() > 0 && act.size() > 0)
            chk({tag, " frame_done cycle"}, fdq[0], act[act.size()-1].cyc + 1);
    endtask

    task automatic clear_q();
        exp_q.delete();
        act1.delete();
        act3.delete();
        fdq1.delete();
        fdq3.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bg3p  = '{default: '0};
        spr3p = '{default: '0};

        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst vga_plot",    int'(vp1), 0);
        chk("rst vga_x",       int'(vx1), 0);
        chk("rst vga_y",       int'(vy1), 0);
        chk("rst vga_colour",  int'(vc1), 0);
        chk("rst spr_address", int'(sa1), 0);
        chk("rst frame_done",  int'(fd1), 0);
        chk("rst busy",        int'(bz1), 0);
        chk("rst L3 vga_plot", int'(vp3), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // ---- frame A: full frame, no sprite ----
        spr_mode = 1; mole_show = 0; e_show = 0;
        run_rect(0, 159, 0, 119, 0, 1, -1);
        chk("A busy in flush", int'(bz1), 1);
        wait_done();
        check_dut("A L1", act1, fdq1, 1);
        check_dut("A L3", act3, fdq3, 3);
        chk("A busy after", int'(bz1), 0);
        if (act1.size() > 0) begin
            chk("A last x", act1[act1.size()-1].x, 159);
            chk("A last y", act1[act1.size()-1].y, 119);
        end
        chk("A colour (159,119)", find_col(act1, 159, 119), 9'h0FF);
        clear_q();

        // ---- frame B: mole at (40,30), key at sprite address 0, off-screen drops ----
        spr_mode = 0; mole_x = 40; mole_y = 30; mole_show = 1;
        e_sx = 40; e_sy = 30; e_show = 1;
        drive_pix(160, 30, 0);
        drive_pix(10, 120, 0);
        idle();
        run_rect(38, 74, 28, 64, 0, 1, -1);
        wait_done();
        check_dut("B L1", act1, fdq1, 1);
        check_dut("B L3", act3, fdq3, 3);
        chk("B (41,30) sprite", find_col(act1, 41, 30), 9'h0E0);
        chk("B (40,30) keyed",  find_col(act1, 40, 30), 9'h0E8);
        chk("B (72,30) right",  find_col(act1, 72, 30), 9'h108);
        chk("B (40,62) below",  find_col(act1, 40, 62), 9'h0E8);
        chk("B (71,61) corner", find_col(act3, 71, 61), 9'h0E0);
        chk("B x=160 dropped",  find_col(act1, 160, 30), -1);
        chk("B y=120 dropped",  find_col(act1, 10, 120), -1);
        clear_q();

        // ---- frame C: mole at (150,110), clipped, no wrap ----
        spr_mode = 1; mole_x = 150; mole_y = 110;
        e_sx = 150; e_sy = 110;
        run_rect(0, 159, 0, 2, 0, 0, -1);
        run_rect(0, 159, 108, 119, 0, 1, -1);
        wait_done();
        check_dut("C L1", act1, fdq1, 1);
        check_dut("C L3", act3, fdq3, 3);
        chk("C (151,110)", find_col(act1, 151, 110), 9'h054);
        chk("C (159,119)", find_col(act1, 159, 119), 9'h07C);
        chk("C (150,110)", find_col(act1, 150, 110), 9'h156);
        chk("C (149,110)", find_col(act1, 149, 110), 341);
        chk("C (5,2)",     find_col(act1, 5, 2), 325);
        clear_q();

        // ---- frame D: mole_x moves mid-frame, ignored ----
        mole_x = 40; mole_y = 30;
        e_sx = 40; e_sy = 30;
        run_rect(38, 90, 30, 31, 0, 0, -1);
        mole_x = 80;
        run_rect(38, 90, 32, 33, 0, 1, -1);
        wait_done();
        check_dut("D L1", act1, fdq1, 1);
        check_dut("D L3", act3, fdq3, 3);
        chk("D (45,32)", find_col(act1, 45, 32), 9'h010);
        chk("D (85,33)", find_col(act1, 85, 33), 9'h0F5);
        clear_q();

        // ---- frame E: new position now in effect ----
        e_sx = 80;
        run_rect(38, 120, 30, 33, 0, 1, -1);
        wait_done();
        check_dut("E L1", act1, fdq1, 1);
        check_dut("E L3", act3, fdq3, 3);
        chk("E (85,33)", find_col(act1, 85, 33), 9'h030);
        chk("E (45,32)", find_col(act1, 45, 32), 45);
        clear_q();

        // ---- reset mid-frame at pixel 5000 ----
        mole_show = 0; e_show = 0;
        run_rect(0, 159, 0, 119, 0, 1, 5000);
        @(negedge clock);
        resetn = 1'b0;
        pix_valid = 1'b0;
        rst_cyc = cyc;
        #1;
        chk("R vga_plot L1 in reset", int'(vp1), 0);
        chk("R vga_plot L3 in reset", int'(vp3), 0);
        chk("R busy in reset", int'(bz1), 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (10) @(negedge clock);
        late = 0;
        foreach (act1[i]) if (act1[i].cyc > rst_cyc) late++;
        foreach (act3[i]) if (act3[i].cyc > rst_cyc) late++;
        chk("R plots after reset", late, 0);
        chk("R frame_done after reset", fdq1.size() + fdq3.size(), 0);
        @(negedge clock);
        scan_done = 1'b1;
        @(negedge clock);
        scan_done = 1'b0;
        repeat (8) @(negedge clock);
        chk("R scan_done in IDLE", fdq1.size() + fdq3.size(), 0);
        chk("R busy idle", int'(bz1) + int'(bz3), 0);
        clear_q();

        // ---- clean frame after reset ----
        mole_x = 40; mole_y = 30; mole_show = 1;
        e_sx = 40; e_sy = 30; e_show = 1;
        run_rect(36, 60, 28, 40, 0, 1, -1);
        wait_done();
        check_dut("P L1", act1, fdq1, 1);
        check_dut("P L3", act3, fdq3, 3);
        clear_q();

        // ---- full frame with a gap after every 4th pixel ----
        mole_x = 150; mole_y = 110;
        e_sx = 150; e_sy = 110;
        run_rect(0, 159, 0, 119, 1, 1, -1);
        wait_done();
        check_dut("G L1", act1, fdq1, 1);
        check_dut("G L3", act3, fdq3, 3);
        clear_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Downstream of the background scan stage: consumes its per-pixel stream (background ROM address already issued, pixel x/y) plus the background ROM colour.
- Overlays one mole sprite (position and visibility from game FSM) with colour-key transparency.
- Drives VGA adapter plot interface (x, y, colour, plot), 160x120 frame.
- Emits frame_done aligned with the final plotted pixel.

Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- SPR_W, 32, sprite width
- SPR_H, 32, sprite height
- ROM_LAT, 1, read latency (cycles) of both background and sprite ROMs, 1..3
- CW, 9, colour width (3 bits per channel)
- KEY, 9'h1FF, transparent sprite colour

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- pix_valid  in  1  background stream pixel valid this cycle
- pix_x  in  8  background pixel x (0..159)
- pix_y  in  8  background pixel y (0..119)
- scan_done  in  1  one-cycle pulse from scan stage after last pixel
- bg_colour  in  CW  background ROM data, ROM_LAT cycles after pix_valid
- mole_x  in  8  sprite top-left x
- mole_y  in  8  sprite top-left y
- mole_show  in  1  sprite enabled
- spr_address  out  10  sprite ROM address (dy*SPR_W+dx)
- spr_colour  in  CW  sprite ROM data, ROM_LAT cycles after spr_address
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  CW  plot colour
- vga_plot  out  1  write enable to VGA adapter
- frame_done  out  1  one-cycle pulse after last plot of frame
- busy  out  1  high while a frame is in flight

Behaviour:
- Reset (async, resetn=0): vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, spr_address=0, frame_done=0, busy=0, all pipeline valids cleared, state IDLE, latched sprite regs cleared (show=0).
- FSM: IDLE -> DRAW on first pix_valid; DRAW -> FLUSH on scan_done; FLUSH counts ROM_LAT+1 cycles then pulses frame_done, -> IDLE.
- busy = (state != IDLE).
- Sprite latch: mole_x/mole_y/mole_show sampled into internal regs only in IDLE on the cycle pix_valid first rises; held constant for the whole frame (no tearing). Changes during DRAW/FLUSH are ignored until next frame.
- Stage 0 (cycle of pix_valid): dx = pix_x - sx, dy = pix_y - sy, 9-bit unsigned subtraction; hit = show && pix_x>=sx && pix_x<sx+SPR_W && pix_y>=sy && pix_y<sy+SPR_H (9-bit compare; sprite clipped at right/bottom edge, no wrap). spr_address registered = dy[4:0]*SPR_W + dx[4:0] when hit, else unchanged.
- Pipeline: valid, x, y, hit delayed ROM_LAT+1 register stages so they align with ROM data registered once.
- Output stage: vga_plot = delayed valid; vga_x = x; vga_y = y[6:0]; vga_colour = (hit && spr_colour != KEY) ? spr_colour : bg_colour.
- Total latency pix_valid -> vga_plot = ROM_LAT+1 cycles; throughput 1 pixel/cycle; gaps in pix_valid pass through as vga_plot=0.
- Pixels with pix_x>=SCR_W or pix_y>=SCR_H are dropped (vga_plot stays 0).
- scan_done coincident with a pix_valid: that pixel is processed normally, FLUSH still waits ROM_LAT+1 cycles so frame_done follows the last vga_plot by exactly 1 cycle.
- scan_done in IDLE: ignored (no frame_done).
- pix_valid during FLUSH: processed through pipeline but does not restart FSM; frame_done timing unchanged.
- Reset mid-frame: pipeline flushed immediately, no further plots, no frame_done.

Decomposition:
- Shared package: SCR_W/SCR_H, colour width, KEY, game state encodings (Start, Game, Game_Hit, Game_Miss, GameEnd) already used by the scan stage and FSM.
- One sub-module: delay_pipe (parameterised depth/width shift register with async active-low clear) for the valid/x/y/hit alignment.

Test Plan:
- Full frame, mole_show=0, bg ROM returns colour=address[8:0], ROM_LAT=1: 19200 plots, each vga_plot 2 cycles after pix_valid, colour matches bg, frame_done 1 cycle after last plot (x=159,y=119).
- mole at (40,30) shown, sprite ROM returns 9'h0E0 except address 0 returns KEY: pixel (41,30) plots 9'h0E0; (40,30) plots bg; (72,30) and (40,62) plot bg.
- mole at (150,110): pixels x 150..159, y 110..119 take sprite colour; no wrap to x=0..21 or y=0..21.
- mole_x changed 40->80 mid-frame: entire frame uses 40; next frame uses 80.
- resetn low at pixel 5000 for 1 cycle: vga_plot=0 within same cycle, no frame_done; next frame starts clean from IDLE.
- ROM_LAT=3 with 1-cycle gaps every 4th pixel: latency 4 cycles, gaps appear as vga_plot=0, plot count 19200.
